// File: rtl/acc_inval_issuer.sv
// Accelerator-side invalidation issuer: turns accelerator store addresses into D$ line
// invalidations for the core. Optional line coalescing is enabled by ACC_INVAL_COALESCE_EN.
module acc_inval_issuer #(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned LineOffset = 4,
    parameter int unsigned Depth      = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     acc_cons_en_i,
    input  logic [AddrWidth-1:0]     wr_addr_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    output logic [AddrWidth-1:0]     inval_addr_o,
    output logic                     inval_valid_o,
    input  logic                     inval_ready_i,
    output logic [$clog2(Depth):0]   pending_o,
    output logic                     idle_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [AddrWidth-1:0] LineMask =
        {{(AddrWidth - LineOffset){1'b1}}, {LineOffset{1'b0}}};
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  mem_q [Depth];
    logic [AddrWidth-1:0]  mem_d [Depth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]         count_q, count_d;

    logic [AddrWidth-1:0]  line;
    logic                  full, empty, dup, ready_raw, push, pop;

    assign line  = wr_addr_i & LineMask;
    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);

`ifdef ACC_INVAL_COALESCE_EN
    logic [AddrWidth-1:0] tag_q, tag_d;
    logic                 tag_valid_q, tag_valid_d;

    assign dup = tag_valid_q && (line == tag_q);
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        ready_raw = 1'b0;
        unique case (state_q)
            StIdle:   ready_raw = 1'b1;
            StActive: ready_raw = !full || dup;
            StDrain:  ready_raw = 1'b0;
            default:  ready_raw = 1'b0;
        endcase
    end

    // Handshakes are masked during reset so nothing completes in the reset cycle.
    assign wr_ready_o    = ready_raw && !rst_i;
    assign inval_valid_o = !empty && !rst_i;
    assign inval_addr_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign pending_o     = count_q;
    assign idle_o        = (state_q == StIdle);

    assign push = (state_q == StActive) && wr_valid_i && wr_ready_o && !dup;
    assign pop  = inval_valid_o && inval_ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (acc_cons_en_i) state_d = StActive;
            StActive: if (!acc_cons_en_i) state_d = empty ? StIdle : StDrain;
            StDrain: begin
                if (acc_cons_en_i)  state_d = StActive;
                else if (empty)     state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = line;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

`ifdef ACC_INVAL_COALESCE_EN
    // The tag tracks the newest entry; it is the head only when a single entry remains.
    always_comb begin
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        if (state_q == StActive && state_d != StActive) begin
            tag_valid_d = 1'b0;
        end else if (push) begin
            tag_d       = line;
            tag_valid_d = 1'b1;
        end else if (pop && count_q == (PtrW + 1)'(1)) begin
            tag_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_acc_inval_issuer.sv
// Self-checking bench for acc_inval_issuer: fixed vector table, directed corner sequences and
// randomized traffic against a queue-based reference model. Honours ACC_INVAL_COALESCE_EN.
module tb_acc_inval_issuer;

`ifdef ACC_INVAL_COALESCE_EN
    localparam bit Coal = 1'b1;
`else
    localparam bit Coal = 1'b0;
`endif
    localparam int Depth = 8;

    logic        clk = 1'b0;
    logic        rst, en, wv, ir;
    logic [63:0] wa;
    logic        wr_ready, inval_valid, idle;
    logic [63:0] inval_addr;
    logic [3:0]  pending;

    int n_checks = 0;
    int n_errors = 0;

    acc_inval_issuer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .acc_cons_en_i (en),
        .wr_addr_i     (wa),
        .wr_valid_i    (wv),
        .wr_ready_o    (wr_ready),
        .inval_addr_o  (inval_addr),
        .inval_valid_o (inval_valid),
        .inval_ready_i (ir),
        .pending_o     (pending),
        .idle_o        (idle)
    );

    always #5 clk = ~clk;

    // Reference model: pending line queue, operating mode and last-pushed-line tag.
    bit [63:0] mq[$];
    int        mmode = 0; // 0 idle, 1 tracking, 2 draining
    bit        tag_v = 1'b0;
    bit [63:0] tag = '0;

    function automatic bit [63:0] m_line();
        return wa & ~64'hF;
    endfunction

    function automatic bit m_dup();
        return Coal && tag_v && (m_line() == tag);
    endfunction

    function automatic bit m_ready();
        if (rst) return 1'b0;
        if (mmode == 0) return 1'b1;
        if (mmode == 2) return 1'b0;
        return (mq.size() < Depth) || m_dup();
    endfunction

    function automatic bit m_valid();
        return !rst && (mq.size() != 0);
    endfunction

    function automatic bit [63:0] m_addr();
        return (mq.size() != 0) ? mq[0] : 64'h0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check(input string ctx);
        chk({ctx, " wr_ready"}, 64'(wr_ready), 64'(m_ready()));
        chk({ctx, " inval_valid"}, 64'(inval_valid), 64'(m_valid()));
        chk({ctx, " inval_addr"}, inval_addr, m_addr());
        chk({ctx, " pending"}, 64'(pending), 64'(mq.size()));
        chk({ctx, " idle"}, 64'(idle), 64'(mmode == 0));
    endtask

    task automatic model_update();
        bit push, pop, empty;
        int nmode;
        if (rst) begin
            mq.delete();
            mmode = 0;
            tag_v = 1'b0;
        end else begin
            empty = (mq.size() == 0);
            push  = (mmode == 1) && wv && m_ready() && !m_dup();
            pop   = m_valid() && ir;
            nmode = mmode;
            if (mmode == 0 && en) nmode = 1;
            else if (mmode == 1 && !en) nmode = empty ? 0 : 2;
            else if (mmode == 2) nmode = en ? 1 : (empty ? 0 : 2);
            if (mmode == 1 && nmode != 1) tag_v = 1'b0;
            else if (push) begin
                tag   = m_line();
                tag_v = 1'b1;
            end else if (pop && mq.size() == 1) tag_v = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(m_line());
            mmode = nmode;
        end
    endtask

    // Inputs change 1ns after posedge; outputs are sampled at the following negedge.
    task automatic drive(input logic r, input logic e, input logic v, input logic [63:0] a,
                         input logic i);
        rst = r; en = e; wv = v; wa = a; ir = i;
        @(negedge clk);
    endtask

    task automatic commit();
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en, wv;
        logic [63:0] wa;
        logic        ir;
        logic        rdy, vld;
        logic [63:0] addr;
        logic [3:0]  pend;
        logic        idle;
    } vec_t;

    vec_t tbl[16];
    logic [63:0] exp_q[$];
    logic        e;

    initial begin
        // Stores while disabled, single-line issue, then a 3-entry drain.
        tbl[0]  = '{1'b0, 1'b1, 64'h10,   1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 64'h20,   1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 64'h30,   1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 64'h1008, 1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h1000, 4'd1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 64'h3000, 1'b0, 1'b1, 1'b0, 64'h0,    4'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 64'h3010, 1'b0, 1'b1, 1'b1, 64'h3000, 4'd1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 64'h3020, 1'b0, 1'b1, 1'b1, 64'h3000, 4'd2, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 64'h3000, 4'd3, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 64'h4000, 1'b1, 1'b0, 1'b1, 64'h3000, 4'd3, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 64'h3010, 4'd2, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 64'h3020, 4'd1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 64'h0,    4'd0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 1'b1};

        rst = 1'b1; en = 1'b0; wv = 1'b0; wa = '0; ir = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
            commit();
        end

        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("reset wr_ready", 64'(wr_ready), 64'd1);
        chk("reset inval_valid", 64'(inval_valid), 64'd0);
        chk("reset inval_addr", inval_addr, 64'h0);
        chk("reset pending", 64'(pending), 64'd0);
        chk("reset idle", 64'(idle), 64'd1);
        commit();

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, tbl[i].en, tbl[i].wv, tbl[i].wa, tbl[i].ir);
            chk($sformatf("tbl%0d wr_ready", i), 64'(wr_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d inval_valid", i), 64'(inval_valid), 64'(tbl[i].vld));
            chk($sformatf("tbl%0d inval_addr", i), inval_addr, tbl[i].addr);
            chk($sformatf("tbl%0d pending", i), 64'(pending), 64'(tbl[i].pend));
            chk($sformatf("tbl%0d idle", i), 64'(idle), 64'(tbl[i].idle));
            commit();
        end

        // FIFO fill to full with the consumer stalled, then in-order drain.
        drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        commit();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 1'b1, 64'h5000 + 64'(i) * 64'h10, 1'b0);
            chk($sformatf("fill%0d wr_ready", i), 64'(wr_ready), 64'(i < 8));
            if (i > 0) chk($sformatf("fill%0d head held", i), inval_addr, 64'h5000);
            commit();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
            chk($sformatf("drain%0d valid", i), 64'(inval_valid), 64'd1);
            chk($sformatf("drain%0d addr", i), inval_addr, 64'h5000 + 64'(i) * 64'h10);
            chk($sformatf("drain%0d pending", i), 64'(pending), 64'(8 - i));
            commit();
        end
        drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        chk("drained pending", 64'(pending), 64'd0);
        commit();

        // Same-line stores: coalesced into one entry when enabled.
        exp_q = '{64'h2000, 64'h2004, 64'h200C, 64'h2010};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, exp_q[i], 1'b0);
            chk($sformatf("coal%0d wr_ready", i), 64'(wr_ready), 64'd1);
            commit();
        end
        if (Coal) exp_q = '{64'h2000, 64'h2010};
        else exp_q = '{64'h2000, 64'h2000, 64'h2000, 64'h2010};
        for (int i = 0; i < exp_q.size(); i++) begin
            drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
            if (i == 0) chk("coal pending", 64'(pending), 64'(exp_q.size()));
            chk($sformatf("coal issue%0d", i), inval_addr, exp_q[i]);
            chk($sformatf("coal valid%0d", i), 64'(inval_valid), 64'd1);
            commit();
        end
        drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
        chk("coal done valid", 64'(inval_valid), 64'd0);
        commit();

        // Reset with five entries pending and the request raised.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 64'h6000 + 64'(i) * 64'h10, 1'b0);
            commit();
        end
        drive(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        chk("rst cycle valid", 64'(inval_valid), 64'd0);
        commit();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        chk("post-rst valid", 64'(inval_valid), 64'd0);
        chk("post-rst pending", 64'(pending), 64'd0);
        chk("post-rst wr_ready", 64'(wr_ready), 64'd1);
        chk("post-rst idle", 64'(idle), 64'd1);
        commit();

        // Randomized traffic against the reference model.
        e = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) e = !e;
            drive(($urandom_range(99) == 0), e, ($urandom_range(9) < 7),
                  64'h7000 + 64'($urandom_range(3)) * 64'h10 + 64'($urandom_range(15)),
                  ($urandom_range(3) != 0));
            model_check($sformatf("rand%0d", i));
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
